ahb2apb_bridge_mux: RTL and testbench

Parametrised AHB-Lite slave to APB master bridge. It replaces the single-slave bridge and drives NUM_SLV APB completers through a one-hot PSEL vector, using an address-field decode. Over the previous bridge it adds PREADY wait-state support, PSLVERR-to-AHB ERROR signalling, decode-miss errors and an optional access timeout. It sits between the AHB-Lite interconnect and the peripheral cluster.

---
 rtl/ahb2apb_bridge_mux.sv | 146 ++++++++++++++
 tb/tb_ahb2apb_bridge_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge_mux.sv
// AHB-Lite slave to multi-completer APB master bridge.
// PREADY waits, PSLVERR/decode-miss/timeout reported as two-cycle AHB ERROR.
//
// Ports:
//   HCLK, HRESETn        clock, async active-low reset
//   HSEL..HREADY         AHB-Lite slave address/data phase inputs
//   HREADYOUT/HRESP      AHB response, HRDATA registered read data
//   PADDR..PENABLE       APB request, PSEL one-hot over NUM_SLV
//   PRDATA/PREADY/PSLVERR per-completer APB responses
module ahb2apb_bridge_mux #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int NUM_SLV      = 4,
  parameter int SLV_ADDR_LSB = 12,
  parameter int TIMEOUT      = 0
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      HSEL,
  input  logic [1:0]                HTRANS,
  input  logic [ADDR_W-1:0]         HADDR,
  input  logic                      HWRITE,
  input  logic [DATA_W-1:0]         HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [DATA_W-1:0]         HRDATA,
  output logic [ADDR_W-1:0]         PADDR,
  output logic [DATA_W-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WWAIT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  logic [2:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_hrdata;
  logic              r_pwrite;

  logic [IDX_W-1:0]  w_idx;
  logic              w_capture;
  logic              w_miss;
  logic              w_apb;
  logic              w_rdy;
  logic              w_err;
  logic              w_tmo;
  logic [DATA_W-1:0] w_prd;
  logic [NUM_SLV-1:0] w_psel;
  logic              w_unused;

  assign w_unused  = HTRANS[0];
  assign w_idx     = HADDR[SLV_ADDR_LSB +: IDX_W];
  // Captures are only accepted in IDLE; ERR2 forces the master to re-issue.
  assign w_capture = HSEL & HREADY & HTRANS[1] & (r_state == S_IDLE);
  assign w_miss    = {1'b0, w_idx} >= (IDX_W+1)'(NUM_SLV);
  assign w_apb     = (r_state == S_SETUP) | (r_state == S_ACCESS);
  assign w_tmo     = (TIMEOUT != 0) & (r_cnt == CNT_LAST) & ~w_rdy;

  always_comb begin
    w_rdy  = 1'b0;
    w_err  = 1'b0;
    w_prd  = '0;
    w_psel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_rdy     = PREADY[i];
        w_err     = PSLVERR[i];
        w_prd     = PRDATA[i*DATA_W +: DATA_W];
        w_psel[i] = w_apb;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_hrdata <= '0;
      r_pwrite <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_paddr  <= HADDR;
            r_pwrite <= HWRITE;
            r_idx    <= w_idx;
            r_cnt    <= '0;
            if (w_miss)      r_state <= S_ERR1;
            else if (HWRITE) r_state <= S_WWAIT;
            else             r_state <= S_SETUP;
          end
        end
        S_WWAIT: begin
          r_pwdata <= HWDATA;
          r_cnt    <= '0;
          r_state  <= S_SETUP;
        end
        S_SETUP: r_state <= S_ACCESS;
        S_ACCESS: begin
          if (w_rdy) begin
            if (!r_pwrite) r_hrdata <= w_err ? '0 : w_prd;
            r_state <= w_err ? S_ERR1 : S_IDLE;
          end else if (w_tmo) begin
            r_state <= S_ERR1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ERR1:  r_state <= S_ERR2;
        S_ERR2:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign HREADYOUT = (r_state == S_IDLE) | (r_state == S_ERR2);
  assign HRESP     = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign HRDATA    = r_hrdata;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PWRITE    = r_pwrite;
  assign PSEL      = w_psel;
  assign PENABLE   = (r_state == S_ACCESS);

endmodule

// File: tb/tb_ahb2apb_bridge_mux.sv
// Bench for ahb2apb_bridge_mux: directed test-plan transfers then random ones,
// each checked cycle by cycle against an expected response list per transfer.
module tb_ahb2apb_bridge_mux;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int NS  = 3;
  localparam int TO  = 8;
  localparam int LSB = 12;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b1;
  logic           HSEL = 1'b0;
  logic [1:0]     HTRANS = 2'b00;
  logic [AW-1:0]  HADDR = '0;
  logic           HWRITE = 1'b0;
  logic [DW-1:0]  HWDATA = '0;
  logic           HREADY = 1'b1;
  logic           HREADYOUT;
  logic           HRESP;
  logic [DW-1:0]  HRDATA;
  logic [AW-1:0]  PADDR;
  logic [DW-1:0]  PWDATA;
  logic           PWRITE;
  logic [NS-1:0]  PSEL;
  logic           PENABLE;
  logic [NS*DW-1:0] PRDATA = '0;
  logic [NS-1:0]  PREADY = '0;
  logic [NS-1:0]  PSLVERR = '0;

  ahb2apb_bridge_mux #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS),
    .SLV_ADDR_LSB(LSB), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_hrdata = '0;
  logic [DW-1:0] exp_pwdata = '0;

  // One expected bus cycle: acc = access-phase number, -2 = final error cycle
  typedef struct {
    bit hro;
    bit resp;
    bit sel;
    bit en;
    int acc;
    bit last;
  } cyc_t;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic noise();
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    PRDATA  = {$urandom, $urandom, $urandom};
  endtask

  task automatic xfer(input logic [AW-1:0] addr, input bit wr,
                      input logic [DW-1:0] wd, input int waits,
                      input bit serr, input logic [DW-1:0] rd,
                      input int rst_at, input bit poke, input string nm);
    cyc_t q[$];
    int idx;
    bit miss, tmo, fail;
    int n;
    logic [NS-1:0] oh;
    logic [DW-1:0] new_hr;
    idx  = int'(addr[LSB +: 2]);
    miss = idx >= NS;
    tmo  = !miss && waits >= TO;
    fail = miss || tmo || serr;
    oh   = miss ? '0 : NS'(1 << idx);
    new_hr = exp_hrdata;
    if (!miss && !wr && !tmo) new_hr = serr ? '0 : rd;
    if (!miss) begin
      if (wr) q.push_back('{0, 0, 0, 0, -1, 0});
      q.push_back('{0, 0, 1, 0, -1, 0});
      n = tmo ? TO : waits + 1;
      for (int j = 0; j < n; j++) q.push_back('{0, 0, 1, 1, j, 0});
      if (wr) exp_pwdata = wd;
    end
    if (fail) begin
      q.push_back('{0, 1, 0, 0, -1, 0});
      q.push_back('{1, 1, 0, 0, -2, 0});
    end
    q.push_back('{1, 0, 0, 0, -1, 1});

    chk({nm, "_idle_in"}, 64'(HREADYOUT), 64'(1));
    HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1;
    HADDR = addr; HWRITE = wr; HWDATA = $urandom;
    noise();
    tick();
    foreach (q[i]) begin
      HSEL = 1'($urandom); HTRANS = 2'b00; HREADY = 1'($urandom);
      HADDR = $urandom; HWRITE = 1'($urandom); HWDATA = wd;
      noise();
      if (q[i].acc >= 0) begin
        PREADY[idx]  = q[i].acc >= waits;
        PSLVERR[idx] = serr && q[i].acc >= waits;
        PRDATA[idx*DW +: DW] = rd;
      end
      if (q[i].acc == -2 && poke) begin
        HSEL = 1'b1; HTRANS = 2'b10; HREADY = 1'b1;
        HADDR = 32'h0000_0000; HWRITE = 1'b0;
      end
      chk($sformatf("%s_c%0d_hreadyout", nm, i), 64'(HREADYOUT),
          64'(q[i].hro));
      chk($sformatf("%s_c%0d_hresp", nm, i), 64'(HRESP), 64'(q[i].resp));
      chk($sformatf("%s_c%0d_psel", nm, i), 64'(PSEL),
          64'(q[i].sel ? oh : '0));
      chk($sformatf("%s_c%0d_penable", nm, i), 64'(PENABLE),
          64'(q[i].en));
      if (q[i].sel) begin
        chk($sformatf("%s_c%0d_paddr", nm, i), 64'(PADDR), 64'(addr));
        chk($sformatf("%s_c%0d_pwrite", nm, i), 64'(PWRITE), 64'(wr));
        chk($sformatf("%s_c%0d_pwdata", nm, i), 64'(PWDATA),
            64'(exp_pwdata));
      end
      if (q[i].last) begin
        exp_hrdata = new_hr;
        chk({nm, "_hrdata"}, 64'(HRDATA), 64'(exp_hrdata));
      end
      if (q[i].acc >= 0 && q[i].acc == rst_at) begin
        #1 HRESETn = 1'b0;
        #1;
        chk({nm, "_rst_psel"}, 64'(PSEL), 64'(0));
        chk({nm, "_rst_penable"}, 64'(PENABLE), 64'(0));
        chk({nm, "_rst_hreadyout"}, 64'(HREADYOUT), 64'(1));
        chk({nm, "_rst_hresp"}, 64'(HRESP), 64'(0));
        chk({nm, "_rst_hrdata"}, 64'(HRDATA), 64'(0));
        chk({nm, "_rst_paddr"}, 64'(PADDR), 64'(0));
        exp_hrdata = '0;
        exp_pwdata = '0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        HTRANS = 2'b00;
        tick();
        return;
      end
      tick();
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int ix, wt;
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("rst_hresp", 64'(HRESP), 64'(0));
    chk("rst_hrdata", 64'(HRDATA), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();

    xfer(32'h0000_1004, 1, 32'hDEAD_BEEF, 0, 0, 0, -1, 0, "wr1");
    xfer(32'h0000_2010, 0, 0, 2, 0, 32'h1234_5678, -1, 0, "rd2");
    xfer(32'h0000_0040, 1, 32'hCAFE_0001, 0, 1, 0, -1, 1, "wrerr0");
    xfer(32'h0000_3000, 0, 0, 0, 0, 0, -1, 1, "miss3");
    xfer(32'h0000_1008, 0, 0, 20, 0, 32'h5555_AAAA, -1, 0, "tmo");
    xfer(32'h0000_1010, 0, 0, TO - 1, 0, 32'hA5A5_0F0F, -1, 0, "notmo");

    HSEL = 1'b1; HTRANS = 2'b01; HREADY = 1'b1; HADDR = 32'h0000_1000;
    tick();
    chk("busy_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("busy_psel", 64'(PSEL), 64'(0));
    HTRANS = 2'b10; HREADY = 1'b0;
    tick();
    HTRANS = 2'b00; HREADY = 1'b1;
    tick();
    chk("nohready_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("nohready_psel", 64'(PSEL), 64'(0));

    xfer(32'h0000_2000, 0, 0, 3, 0, 32'h0BAD_F00D, 1, 0, "rstmid");
    xfer(32'h0000_2004, 0, 0, 0, 0, 32'h7777_1111, -1, 0, "postrst");

    for (int k = 0; k < 40; k++) begin
      ix = $urandom_range(0, 3);
      a = $urandom;
      a[LSB +: 2] = 2'(ix);
      wt = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 3)
                                       : $urandom_range(0, 3);
      xfer(a, 1'($urandom), $urandom, wt, $urandom_range(0, 3) == 0,
           $urandom, -1, 1'($urandom), $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
